// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - opcodes, FSM states and datapath select encodings for the multi-cycle controller
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_ALU_R  = 4'd1,
        CLS_ALU_I  = 4'd2,
        CLS_LUI    = 4'd3,
        CLS_AUIPC  = 4'd4,
        CLS_LOAD   = 4'd5,
        CLS_STORE  = 4'd6,
        CLS_BRANCH = 4'd7,
        CLS_JAL    = 4'd8,
        CLS_JALR   = 4'd9,
        CLS_ECALL  = 4'd10
    } instr_class_t;

    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // Low four byte lanes for a B/H/W access; upper lanes of wider datapaths stay 0.
    function automatic logic [3:0] be_from_funct3(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   be_from_funct3 = 4'b0001;
            2'b01:   be_from_funct3 = 4'b0011;
            2'b10:   be_from_funct3 = 4'b1111;
            default: be_from_funct3 = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/rv_main_decoder.sv
// rtl/rv_main_decoder.sv - combinational opcode/funct3 to instruction class, immediate format, byte enables
module rv_main_decoder
    import rv_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    output instr_class_t        cls,
    output logic [2:0]          imm_sel,
    output logic [DATA_W/8-1:0] be,
    output logic                legal
);

    localparam int BE_W = DATA_W / 8;

    always_comb begin
        cls     = CLS_NONE;
        imm_sel = IMM_I;
        legal   = 1'b1;
        case (opcode)
            OP_OP:     cls = CLS_ALU_R;
            OP_IMM:    cls = CLS_ALU_I;
            OP_LUI: begin
                cls     = CLS_LUI;
                imm_sel = IMM_U;
            end
            OP_AUIPC: begin
                cls     = CLS_AUIPC;
                imm_sel = IMM_U;
            end
            OP_LOAD: begin
                cls   = CLS_LOAD;
                legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            end
            OP_STORE: begin
                cls     = CLS_STORE;
                imm_sel = IMM_S;
                legal   = funct3 inside {3'b000, 3'b001, 3'b010};
            end
            OP_BRANCH: begin
                cls     = CLS_BRANCH;
                imm_sel = IMM_B;
            end
            OP_JAL: begin
                cls     = CLS_JAL;
                imm_sel = IMM_J;
            end
            OP_JALR:   cls = CLS_JALR;
            OP_SYSTEM: cls = CLS_ECALL;
            default:   legal = 1'b0;
        endcase
    end

    assign be = BE_W'(be_from_funct3(funct3));

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - RV32I multi-cycle main control FSM with memory watchdog; CTRL_PERF_CNT_EN adds perf counters
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int WAIT_MAX = 255
`ifdef CTRL_PERF_CNT_EN
    ,
    parameter int CNT_W    = 32
`endif
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                branch_taken,
    input  logic                i_mem_ack,
    input  logic                d_mem_ack,
    output logic                i_mem_req,
    output logic                d_mem_req,
    output logic                d_mem_we,
    output logic [DATA_W/8-1:0] D_MEM_BE,
    output logic                pc_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          wb_sel,
    output logic [2:0]          imm_sel,
    output logic [6:0]          alu_op,
    output logic                halted,
    output logic                illegal,
    output logic                mem_err
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    instret_cnt
`endif
);

    localparam int BE_W = DATA_W / 8;
    localparam int WD_W = $clog2(WAIT_MAX + 1);
    // Request cycle number WAIT_MAX (1-based) is the last one allowed to see its ack.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WAIT_MAX - 1);

    state_t            state;
    state_t            nxt;
    logic [WD_W-1:0]   wait_cnt;
    logic              wait_active;
    logic              cur_ack;
    logic              wd_expire;
    logic              set_illegal;
    logic              set_mem_err;
    instr_class_t      cls;
    logic [2:0]        dec_imm;
    logic [BE_W-1:0]   dec_be;
    logic              dec_legal;

    rv_main_decoder #(.DATA_W(DATA_W)) u_dec (
        .opcode  (opcode),
        .funct3  (funct3),
        .cls     (cls),
        .imm_sel (dec_imm),
        .be      (dec_be),
        .legal   (dec_legal)
    );

    assign wait_active = (state == ST_IF) || (state == ST_MEM);
    assign cur_ack     = (state == ST_IF) ? i_mem_ack : d_mem_ack;
    assign wd_expire   = wait_active && !cur_ack && (wait_cnt == WD_LAST);

    always_ff @(posedge CLK) begin
        if (!RSTn) state <= ST_IF;
        else       state <= nxt;
    end

    always_comb begin
        nxt         = state;
        set_illegal = 1'b0;
        set_mem_err = 1'b0;
        case (state)
            ST_IF: begin
                if (i_mem_ack) begin
                    nxt = ST_ID;
                end else if (wd_expire) begin
                    nxt         = ST_HALT;
                    set_mem_err = 1'b1;
                end
            end
            ST_ID: begin
                if (!dec_legal) begin
                    nxt         = ST_HALT;
                    set_illegal = 1'b1;
                end else if (cls == CLS_ECALL) begin
                    nxt = ST_HALT;
                end else begin
                    nxt = ST_EX;
                end
            end
            ST_EX: begin
                case (cls)
                    CLS_LOAD, CLS_STORE: nxt = ST_MEM;
                    CLS_BRANCH:          nxt = ST_IF;
                    default:             nxt = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (d_mem_ack) begin
                    nxt = (cls == CLS_STORE) ? ST_IF : ST_WB;
                end else if (wd_expire) begin
                    nxt         = ST_HALT;
                    set_mem_err = 1'b1;
                end
            end
            ST_WB:   nxt = ST_IF;
            ST_HALT: nxt = ST_HALT;
            default: nxt = ST_HALT;
        endcase
    end

    // Watchdog counts unacked request cycles; any state change clears it for the next request.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            wait_cnt <= '0;
            illegal  <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            if (wait_active && !cur_ack && (nxt == state)) wait_cnt <= wait_cnt + 1'b1;
            else                                            wait_cnt <= '0;
            if (set_illegal) illegal <= 1'b1;
            if (set_mem_err) mem_err <= 1'b1;
        end
    end

    always_comb begin
        i_mem_req = 1'b0;
        d_mem_req = 1'b0;
        d_mem_we  = 1'b0;
        D_MEM_BE  = '0;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        wb_sel    = WB_ALU;
        imm_sel   = IMM_I;
        alu_op    = 7'd0;
        halted    = (state == ST_HALT);
        if (RSTn) begin
            case (state)
                ST_IF: begin
                    i_mem_req = 1'b1;
                    alu_src_a = SRC_A_PC;
                    alu_src_b = SRC_B_FOUR;
                    ir_write  = i_mem_ack;
                    pc_write  = i_mem_ack;
                end
                ST_ID: imm_sel = dec_imm;
                ST_EX: begin
                    imm_sel = dec_imm;
                    alu_op  = opcode;
                    case (cls)
                        CLS_ALU_R, CLS_BRANCH: begin
                            alu_src_a = SRC_A_RS1;
                            alu_src_b = SRC_B_RS2;
                        end
                        CLS_LUI: begin
                            alu_src_a = SRC_A_ZERO;
                            alu_src_b = SRC_B_IMM;
                        end
                        CLS_AUIPC, CLS_JAL: begin
                            alu_src_a = SRC_A_PC;
                            alu_src_b = SRC_B_IMM;
                        end
                        default: begin
                            alu_src_a = SRC_A_RS1;
                            alu_src_b = SRC_B_IMM;
                        end
                    endcase
                    if (cls == CLS_BRANCH) pc_write = branch_taken;
                end
                ST_MEM: begin
                    d_mem_req = 1'b1;
                    d_mem_we  = (cls == CLS_STORE);
                    D_MEM_BE  = dec_be;
                    imm_sel   = dec_imm;
                    alu_src_b = SRC_B_IMM;
                end
                ST_WB: begin
                    reg_write = 1'b1;
                    case (cls)
                        CLS_LOAD: wb_sel = WB_MEM;
                        CLS_JAL, CLS_JALR: begin
                            wb_sel   = WB_PC4;
                            pc_write = 1'b1;
                        end
                        default: wb_sel = WB_ALU;
                    endcase
                end
                default: ;
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != ST_HALT) cycle_cnt <= cycle_cnt + 1'b1;
            if ((nxt == ST_IF) && ((state == ST_EX) || (state == ST_MEM) || (state == ST_WB)))
                instret_cnt <= instret_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

    localparam int DATA_W   = 32;
    localparam int WAIT_MAX = 4;
`ifdef CTRL_PERF_CNT_EN
    localparam int CNT_W    = 4;
`endif

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] ADDI   = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] ECALL  = 7'b1110011;

    logic        clk = 1'b0;
    logic        rstn;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        branch_taken;
    logic        i_mem_ack;
    logic        d_mem_ack;
    logic        i_mem_req, d_mem_req, d_mem_we;
    logic [3:0]  d_mem_be;
    logic        pc_write, ir_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, wb_sel;
    logic [2:0]  imm_sel;
    logic [6:0]  alu_op;
    logic        halted, illegal, mem_err;
`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;
`endif

    logic [8:0] sv;
    assign sv = {i_mem_req, d_mem_req, d_mem_we, pc_write, ir_write, reg_write, halted, illegal, mem_err};

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    multicycle_control #(
        .DATA_W   (DATA_W),
        .WAIT_MAX (WAIT_MAX)
`ifdef CTRL_PERF_CNT_EN
        ,
        .CNT_W    (CNT_W)
`endif
    ) dut (
        .CLK          (clk),
        .RSTn         (rstn),
        .opcode       (opcode),
        .funct3       (funct3),
        .branch_taken (branch_taken),
        .i_mem_ack    (i_mem_ack),
        .d_mem_ack    (d_mem_ack),
        .i_mem_req    (i_mem_req),
        .d_mem_req    (d_mem_req),
        .d_mem_we     (d_mem_we),
        .D_MEM_BE     (d_mem_be),
        .pc_write     (pc_write),
        .ir_write     (ir_write),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .wb_sel       (wb_sel),
        .imm_sel      (imm_sel),
        .alu_op       (alu_op),
        .halted       (halted),
        .illegal      (illegal),
        .mem_err      (mem_err)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        i_mem_ack = 1'b0;
        d_mem_ack = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        #1;
    endtask

    // Instruction fetch with zero-wait ack; returns in ID.
    task automatic fetch(input logic [6:0] op, input logic [2:0] f3);
        opcode = op;
        funct3 = f3;
        i_mem_ack = 1'b1;
        tick();
        i_mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        i_mem_ack = 1'b1;
        tick();
        checks++;
        if (sv !== 9'b0) $display("FAIL reset_forced: sv=%b want %b", sv, 9'b0);
        else passed++;
        i_mem_ack = 1'b0;
        rstn = 1'b1;
        #1;
        checks++;
        if (sv !== 9'b100000000) $display("FAIL reset_if: sv=%b want %b", sv, 9'b100000000);
        else passed++;
        checks++;
        if ({alu_src_a, alu_src_b} !== {2'd1, 2'd2}) $display("FAIL reset_if_src: got %b want %b", {alu_src_a, alu_src_b}, 4'b0110);
        else passed++;
    endtask

    task automatic test_addi();
        do_reset();
        opcode = ADDI;
        funct3 = 3'b000;
        i_mem_ack = 1'b1;
        #1;
        checks++;
        if (sv !== 9'b100110000) $display("FAIL addi_if_ack: sv=%b want %b", sv, 9'b100110000);
        else passed++;
        tick();
        i_mem_ack = 1'b0;
        #1;
        checks++;
        if (sv !== 9'b0) $display("FAIL addi_id: sv=%b want %b", sv, 9'b0);
        else passed++;
        tick();
        checks++;
        if ({sv, alu_op, imm_sel, alu_src_b} !== {9'b0, ADDI, 3'd0, 2'd1})
            $display("FAIL addi_ex: got %b want %b", {sv, alu_op, imm_sel, alu_src_b}, {9'b0, ADDI, 3'd0, 2'd1});
        else passed++;
        tick();
        checks++;
        if ({sv, wb_sel, alu_op} !== {9'b000001000, 2'd0, 7'd0})
            $display("FAIL addi_wb: got %b want %b", {sv, wb_sel, alu_op}, {9'b000001000, 2'd0, 7'd0});
        else passed++;
        tick();
        checks++;
        if (sv !== 9'b100000000) $display("FAIL addi_back_if: sv=%b want %b", sv, 9'b100000000);
        else passed++;
    endtask

    task automatic test_load_store();
        do_reset();
        fetch(LOAD, 3'b010);
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            d_mem_ack = (k == 3);
            #1;
            checks++;
            if ({sv, d_mem_be} !== {9'b010000000, 4'b1111})
                $display("FAIL lw_mem_cycle%0d: got %b want %b", k, {sv, d_mem_be}, {9'b010000000, 4'b1111});
            else passed++;
            tick();
        end
        d_mem_ack = 1'b0;
        #1;
        checks++;
        if ({sv, wb_sel, d_mem_be} !== {9'b000001000, 2'd1, 4'b0000})
            $display("FAIL lw_wb: got %b want %b", {sv, wb_sel, d_mem_be}, {9'b000001000, 2'd1, 4'b0000});
        else passed++;
        tick();
        checks++;
        if (sv !== 9'b100000000) $display("FAIL lw_back_if: sv=%b want %b", sv, 9'b100000000);
        else passed++;

        fetch(STORE, 3'b000);
        tick();
        checks++;
        if ({imm_sel, alu_src_b} !== {3'd1, 2'd1}) $display("FAIL sb_ex: got %b want %b", {imm_sel, alu_src_b}, 5'b00101);
        else passed++;
        tick();
        d_mem_ack = 1'b1;
        #1;
        checks++;
        if ({sv, d_mem_be} !== {9'b011000000, 4'b0001})
            $display("FAIL sb_mem: got %b want %b", {sv, d_mem_be}, {9'b011000000, 4'b0001});
        else passed++;
        tick();
        d_mem_ack = 1'b0;
        #1;
        checks++;
        if (sv !== 9'b100000000) $display("FAIL sb_back_if: sv=%b want %b", sv, 9'b100000000);
        else passed++;

        fetch(STORE, 3'b001);
        tick();
        tick();
        checks++;
        if (d_mem_be !== 4'b0011) $display("FAIL sh_be: got %b want %b", d_mem_be, 4'b0011);
        else passed++;
        d_mem_ack = 1'b1;
        tick();
        d_mem_ack = 1'b0;
    endtask

    task automatic test_branch();
        do_reset();
        branch_taken = 1'b1;
        fetch(BRANCH, 3'b000);
        tick();
        checks++;
        if ({sv, imm_sel} !== {9'b000100000, 3'd2}) $display("FAIL beq_taken_ex: got %b want %b", {sv, imm_sel}, {9'b000100000, 3'd2});
        else passed++;
        tick();
        checks++;
        if (sv !== 9'b100000000) $display("FAIL beq_taken_if: sv=%b want %b", sv, 9'b100000000);
        else passed++;
        branch_taken = 1'b0;
        fetch(BRANCH, 3'b000);
        tick();
        checks++;
        if (sv !== 9'b0) $display("FAIL beq_not_taken_ex: sv=%b want %b", sv, 9'b0);
        else passed++;
        tick();
        checks++;
        if (sv !== 9'b100000000) $display("FAIL beq_not_taken_if: sv=%b want %b", sv, 9'b100000000);
        else passed++;
    endtask

    task automatic test_jal();
        do_reset();
        fetch(JAL, 3'b000);
        tick();
        checks++;
        if ({alu_src_a, imm_sel} !== {2'd1, 3'd4}) $display("FAIL jal_ex: got %b want %b", {alu_src_a, imm_sel}, 5'b01100);
        else passed++;
        tick();
        checks++;
        if ({sv, wb_sel} !== {9'b000101000, 2'd2}) $display("FAIL jal_wb: got %b want %b", {sv, wb_sel}, {9'b000101000, 2'd2});
        else passed++;
        tick();
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int k = 0; k < WAIT_MAX; k++) begin
            checks++;
            if (sv !== 9'b100000000) $display("FAIL wd_wait%0d: sv=%b want %b", k, sv, 9'b100000000);
            else passed++;
            tick();
        end
        checks++;
        if (sv !== 9'b000000101) $display("FAIL wd_halt: sv=%b want %b", sv, 9'b000000101);
        else passed++;
        i_mem_ack = 1'b1;
        tick();
        i_mem_ack = 1'b0;
        checks++;
        if (sv !== 9'b000000101) $display("FAIL wd_halt_sticky: sv=%b want %b", sv, 9'b000000101);
        else passed++;

        do_reset();
        for (int k = 0; k < WAIT_MAX - 1; k++) tick();
        i_mem_ack = 1'b1;
        #1;
        checks++;
        if (sv !== 9'b100110000) $display("FAIL wd_last_ack: sv=%b want %b", sv, 9'b100110000);
        else passed++;
        tick();
        i_mem_ack = 1'b0;
        #1;
        checks++;
        if (sv !== 9'b0) $display("FAIL wd_last_ack_id: sv=%b want %b", sv, 9'b0);
        else passed++;
    endtask

    task automatic test_illegal();
        do_reset();
        fetch(7'b0000000, 3'b000);
        tick();
        checks++;
        if (sv !== 9'b000000110) $display("FAIL illegal_op: sv=%b want %b", sv, 9'b000000110);
        else passed++;
        do_reset();
        checks++;
        if (sv !== 9'b100000000) $display("FAIL illegal_cleared: sv=%b want %b", sv, 9'b100000000);
        else passed++;
        fetch(LOAD, 3'b011);
        tick();
        checks++;
        if (sv !== 9'b000000110) $display("FAIL illegal_ld_f3: sv=%b want %b", sv, 9'b000000110);
        else passed++;
        do_reset();
        fetch(ECALL, 3'b000);
        tick();
        checks++;
        if (sv !== 9'b000000100) $display("FAIL ecall_halt: sv=%b want %b", sv, 9'b000000100);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        fetch(LOAD, 3'b010);
        tick();
        tick();
        checks++;
        if (sv !== 9'b010000000) $display("FAIL rst_mid_mem: sv=%b want %b", sv, 9'b010000000);
        else passed++;
        tick();
        rstn = 1'b0;
        #1;
        checks++;
        if (sv !== 9'b0) $display("FAIL rst_mid_forced: sv=%b want %b", sv, 9'b0);
        else passed++;
        tick();
        rstn = 1'b1;
        #1;
        checks++;
        if (sv !== 9'b100000000) $display("FAIL rst_mid_if: sv=%b want %b", sv, 9'b100000000);
        else passed++;
    endtask

`ifdef CTRL_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        checks++;
        if ({cycle_cnt, instret_cnt} !== 8'h00) $display("FAIL perf_reset: got %h want %h", {cycle_cnt, instret_cnt}, 8'h00);
        else passed++;
        for (int i = 0; i < 16; i++) begin
            fetch(ADDI, 3'b000);
            tick();
            tick();
            tick();
            if (i == 0) begin
                checks++;
                if ({cycle_cnt, instret_cnt} !== 8'h41) $display("FAIL perf_first: got %h want %h", {cycle_cnt, instret_cnt}, 8'h41);
                else passed++;
            end
        end
        checks++;
        if ({cycle_cnt, instret_cnt} !== 8'h00) $display("FAIL perf_wrap: got %h want %h", {cycle_cnt, instret_cnt}, 8'h00);
        else passed++;
        fetch(7'b0000000, 3'b000);
        tick();
        tick();
        tick();
        checks++;
        if ({halted, cycle_cnt, instret_cnt} !== 9'h120) $display("FAIL perf_halt_frozen: got %h want %h", {halted, cycle_cnt, instret_cnt}, 9'h120);
        else passed++;
    endtask
`endif

    initial begin
        rstn = 1'b0;
        opcode = 7'd0;
        funct3 = 3'd0;
        branch_taken = 1'b0;
        i_mem_ack = 1'b0;
        d_mem_ack = 1'b0;
        test_reset();
        test_addi();
        test_load_store();
        test_branch();
        test_jal();
        test_watchdog();
        test_illegal();
        test_reset_mid();
`ifdef CTRL_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
